i2c_burst_reader: RTL and testbench

//  Parametrised I2C master: register-pointer write, repeated START, burst read of
//  1..NBYTES_MAX bytes from any 7-bit slave. Successor of the fixed two-byte
//  msb/lsb reader: runtime slave/register/length, NACK reporting, optional stretch.

---
 rtl/i2c_burst_reader.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_burst_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_reader.sv
// I2C burst-read master: pointer write, repeated START, then 1..NBYTES_MAX byte read.
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_burst_reader #(
    parameter int unsigned CLK_DIV    = 125,
    parameter int unsigned NBYTES_MAX = 4,
    parameter int unsigned LEN_W      = 3
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    start,
    input  logic [6:0]              slave_addr,
    input  logic [7:0]              reg_addr,
    input  logic [LEN_W-1:0]        nbytes,
    output logic                    busy,
    output logic                    done,
    output logic                    ack_err,
    output logic [8*NBYTES_MAX-1:0] rd_data,
    input  logic                    scl_pad_i,
    output logic                    scl_pad_o,
    output logic                    scl_padoen_o,
    input  logic                    sda_pad_i,
    output logic                    sda_pad_o,
    output logic                    sda_padoen_o
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        StIdle, StStart, StWaddr, StWack, StWreg, StRegAck,
        StRstart, StRaddr, StRaddrAck, StRead, StMack, StStop
    } state_t;

    state_t           state;
    logic [1:0]       phase;
    logic [DIV_W-1:0] div;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx;
    logic [7:0]       rx;
    logic [6:0]       addr;
    logic [7:0]       reg_ptr;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] byte_idx;
    logic             nack;
    logic             scl_oe;
    logic             sda_oe;
    logic [1:0]       scl_sync;
    logic [1:0]       sda_sync;
    logic             scl_s;
    logic             sda_s;
    logic             hold;
    logic             tick;
    logic             last;

    assign scl_pad_o    = 1'b0;
    assign sda_pad_o    = 1'b0;
    assign scl_padoen_o = scl_oe;
    assign sda_padoen_o = sda_oe;
    assign scl_s        = scl_sync[1];
    assign sda_s        = sda_sync[1];
    assign last         = (byte_idx == len - LEN_W'(1));

`ifdef I2C_CLK_STRETCH_EN
    // Freeze the quarter after releasing SCL until the line is seen high.
    assign hold = (phase == 2'd1) && !scl_s;
`else
    logic unused_scl;
    assign hold       = 1'b0;
    assign unused_scl = scl_s;
`endif

    assign tick = !hold && (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_pad_i};
            sda_sync <= {sda_sync[0], sda_pad_i};
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state    <= StIdle;
            phase    <= 2'd0;
            div      <= '0;
            bit_cnt  <= 3'd0;
            tx       <= 8'h00;
            rx       <= 8'h00;
            addr     <= 7'h00;
            reg_ptr  <= 8'h00;
            len      <= '0;
            byte_idx <= '0;
            nack     <= 1'b0;
            scl_oe   <= 1'b1;
            sda_oe   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            rd_data  <= '0;
        end else begin
            done <= 1'b0;
            if (state == StIdle) begin
                div <= '0;
                if (start) begin
                    rd_data <= '0;
                    ack_err <= 1'b0;
                    if (nbytes == '0) begin
                        done <= 1'b1;
                    end else begin
                        busy     <= 1'b1;
                        state    <= StStart;
                        phase    <= 2'd0;
                        addr     <= slave_addr;
                        reg_ptr  <= reg_addr;
                        len      <= (nbytes > LEN_W'(NBYTES_MAX)) ? LEN_W'(NBYTES_MAX) : nbytes;
                        byte_idx <= '0;
                        nack     <= 1'b0;
                    end
                end
            end else begin
                div <= (hold || tick) ? '0 : div + DIV_W'(1);
                if (tick) begin
                    phase <= phase + 2'd1;
                    unique case (phase)
                        2'd0: scl_oe <= 1'b1;
                        2'd1: begin
                            if (state == StStart || state == StRstart) sda_oe <= 1'b0;
                            if (state == StStop) sda_oe <= 1'b1;
                        end
                        2'd2: begin
                            if (state != StStop) scl_oe <= 1'b0;
                            if (state == StRead) rx <= {rx[6:0], sda_s};
                            nack <= sda_s;
                        end
                        2'd3: begin
                            case (state)
                                StStart, StRstart: begin
                                    state   <= (state == StStart) ? StWaddr : StRaddr;
                                    tx      <= {addr, (state == StRstart)};
                                    sda_oe  <= addr[6];
                                    bit_cnt <= 3'd7;
                                end
                                StWaddr, StWreg, StRaddr: begin
                                    tx      <= {tx[6:0], 1'b1};
                                    bit_cnt <= bit_cnt - 3'd1;
                                    sda_oe  <= tx[6];
                                    if (bit_cnt == 3'd0) begin
                                        sda_oe <= 1'b1;
                                        state  <= (state == StWaddr) ? StWack :
                                                  (state == StWreg)  ? StRegAck : StRaddrAck;
                                    end
                                end
                                StWack, StRegAck, StRaddrAck: begin
                                    if (nack) begin
                                        state   <= StStop;
                                        sda_oe  <= 1'b0;
                                        ack_err <= 1'b1;
                                    end else if (state == StWack) begin
                                        state   <= StWreg;
                                        tx      <= reg_ptr;
                                        sda_oe  <= reg_ptr[7];
                                        bit_cnt <= 3'd7;
                                    end else begin
                                        state   <= (state == StRegAck) ? StRstart : StRead;
                                        sda_oe  <= 1'b1;
                                        bit_cnt <= 3'd7;
                                    end
                                end
                                StRead: begin
                                    bit_cnt <= bit_cnt - 3'd1;
                                    if (bit_cnt == 3'd0) begin
                                        state  <= StMack;
                                        sda_oe <= last;
                                        for (int k = 0; k < int'(NBYTES_MAX); k++) begin
                                            if (byte_idx == LEN_W'(k)) begin
                                                rd_data[8*(NBYTES_MAX-k)-1 -: 8] <= rx;
                                            end
                                        end
                                    end
                                end
                                StMack: begin
                                    if (last) begin
                                        state  <= StStop;
                                        sda_oe <= 1'b0;
                                    end else begin
                                        state    <= StRead;
                                        sda_oe   <= 1'b1;
                                        bit_cnt  <= 3'd7;
                                        byte_idx <= byte_idx + LEN_W'(1);
                                    end
                                end
                                StStop: begin
                                    state <= StIdle;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                                default: state <= StIdle;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_burst_reader.sv
// Directed bench for i2c_burst_reader with a behavioural open-drain slave (address 0x10).
// Define I2C_CLK_STRETCH_EN to also exercise slave clock stretching.
module tb_i2c_burst_reader;
    localparam logic [6:0] SLV = 7'h10;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  slave_addr = 7'h00;
    logic [7:0]  reg_addr = 8'h00;
    logic [2:0]  nbytes = 3'd0;
    logic        busy, done, ack_err;
    logic [31:0] rd_data;
    logic        scl_pad_o, scl_padoen, sda_pad_o, sda_padoen;
    logic        scl_line, sda_line;

    logic        s_drv = 1'b1;
    int          stretch_cnt = 0;
    int          stretch_req = 0;
    int          stretch_ack = 0;
    logic [7:0]  mem [0:15];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign scl_line = scl_padoen & (stretch_cnt == 0);
    assign sda_line = sda_padoen & s_drv;

    i2c_burst_reader #(
        .CLK_DIV    (4),
        .NBYTES_MAX (4),
        .LEN_W      (3)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .start        (start),
        .slave_addr   (slave_addr),
        .reg_addr     (reg_addr),
        .nbytes       (nbytes),
        .busy         (busy),
        .done         (done),
        .ack_err      (ack_err),
        .rd_data      (rd_data),
        .scl_pad_i    (scl_line),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen)
    );

    // Behavioural slave: detects START/STOP, ACKs its address, auto-increments pointer.
    logic       p_scl = 1'b1, p_sda = 1'b1, s_act = 1'b0, s_rd = 1'b0;
    int         s_bit = 0, s_byte = 0, starts = 0, stops = 0, mack = 0, mnack = 0;
    logic [7:0] s_sh = 8'h00, s_ptr = 8'h00, cur;

    always @(scl_line, sda_line, arst) begin
        if (!arst) begin
            s_act = 1'b0;
            s_drv = 1'b1;
        end else if (scl_line && p_scl && p_sda && !sda_line) begin
            s_act = 1'b1; s_bit = -1; s_byte = 0; s_drv = 1'b1; starts++;
        end else if (scl_line && p_scl && !p_sda && sda_line) begin
            s_act = 1'b0; s_drv = 1'b1; stops++;
        end else if (scl_line && !p_scl && s_act) begin
            if (s_bit >= 0 && s_bit < 8) s_sh = {s_sh[6:0], sda_line};
            else if (s_bit == 8 && s_rd && s_byte > 0) begin
                if (sda_line) begin mnack++; s_act = 1'b0; s_drv = 1'b1; end
                else mack++;
            end
        end else if (!scl_line && p_scl && s_act) begin
            if (s_bit < 0) s_bit = 0;
            else if (s_bit < 8) begin
                s_bit++;
                if (s_bit == 8) begin
                    if (s_byte == 0) begin
                        if (s_sh[7:1] == SLV) begin
                            s_drv = 1'b0; s_rd = s_sh[0];
`ifdef I2C_CLK_STRETCH_EN
                            stretch_req++;
`endif
                        end else begin
                            s_drv = 1'b1; s_act = 1'b0;
                        end
                    end else if (!s_rd) begin
                        s_ptr = s_sh; s_drv = 1'b0;
                    end else s_drv = 1'b1;
                end else if (s_rd && s_byte > 0) begin
                    cur = mem[s_ptr[3:0]];
                    s_drv = cur[7-s_bit];
                end
            end else begin
                if (s_rd && s_byte > 0) s_ptr = s_ptr + 8'd1;
                s_byte++; s_bit = 0;
                cur = mem[s_ptr[3:0]];
                s_drv = s_rd ? cur[7] : 1'b1;
            end
        end
        p_scl = scl_line;
        p_sda = sda_padoen & s_drv;
    end

    always @(posedge clk) begin
        if (stretch_req != stretch_ack) begin
            stretch_ack <= stretch_req;
            stretch_cnt <= 50;
        end else if (stretch_cnt > 0) stretch_cnt <= stretch_cnt - 1;
    end

    logic mon_en = 1'b0;
    int   low_cnt = 0;
    always @(negedge clk) if (mon_en && (scl_line !== 1'b1 || sda_line !== 1'b1)) low_cnt <= low_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: returns busy after start, done seen, done one cycle later, busy cycles.
    task automatic run(input logic [6:0] a, input logic [7:0] r, input logic [2:0] n,
                       output logic b0, output logic got, output logic d2, output int cyc);
        @(negedge clk);
        slave_addr = a; reg_addr = r; nbytes = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0; b0 = busy; got = 1'b0; cyc = 0; d2 = 1'b1;
        for (int i = 0; i < 6000 && !got; i++) begin
            if (busy) cyc++;
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        d2 = done;
    endtask

    logic b0, got, d2;
    int   cyc, m0, n0, st0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        mem[4] = 8'h01; mem[5] = 8'h02; mem[6] = 8'h03; mem[7] = 8'h04;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_scl_oen", scl_padoen, 1'b1);
        chk("rst_sda_oen", sda_padoen, 1'b1);
        chk("rst_pad_o", {scl_pad_o, sda_pad_o}, 2'b00);
        arst = 1'b1;

        // Two-byte read from register 0
        m0 = mack; n0 = mnack; st0 = stops;
        run(SLV, 8'h00, 3'd2, b0, got, d2, cyc);
        chk("t1_busy_rise", b0, 1'b1);
        chk("t1_done", got, 1'b1);
        chk("t1_done_pulse", d2, 1'b0);
        chk("t1_rd_data", rd_data, 32'hA53C_0000);
        chk("t1_ack_err", ack_err, 1'b0);
        chk("t1_master_acks", mack - m0, 1);
        chk("t1_master_nacks", mnack - n0, 1);
        chk("t1_stops", stops - st0, 1);
`ifndef I2C_CLK_STRETCH_EN
        chk("t1_busy_cycles", cyc, 768);
`endif

        // Four-byte read from register 4
        m0 = mack; n0 = mnack;
        run(SLV, 8'h04, 3'd4, b0, got, d2, cyc);
        chk("t3_done", got, 1'b1);
        chk("t3_rd_data", rd_data, 32'h0102_0304);
        chk("t3_master_acks", mack - m0, 3);
        chk("t3_master_nacks", mnack - n0, 1);
`ifndef I2C_CLK_STRETCH_EN
        chk("t3_busy_cycles", cyc, 1056);
`endif

        // Over-length request clamps to four bytes
        run(SLV, 8'h04, 3'd7, b0, got, d2, cyc);
        chk("clamp_rd_data", rd_data, 32'h0102_0304);
`ifndef I2C_CLK_STRETCH_EN
        chk("clamp_busy_cycles", cyc, 1056);
`endif

        // Absent slave: address NACK
        st0 = stops;
        run(7'h7F, 8'h00, 3'd2, b0, got, d2, cyc);
        chk("t2_done", got, 1'b1);
        chk("t2_ack_err", ack_err, 1'b1);
        chk("t2_rd_data", rd_data, 32'h0);
        chk("t2_stops", stops - st0, 1);
`ifndef I2C_CLK_STRETCH_EN
        chk("t2_busy_cycles", cyc, 176);
`endif

        // Zero-length request: immediate done, bus untouched
        @(negedge clk);
        mon_en = 1'b1; nbytes = 3'd0; slave_addr = SLV; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_done", done, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_ack_err_cleared", ack_err, 1'b0);
        @(negedge clk);
        chk("t4_done_pulse", done, 1'b0);
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        chk("t4_bus_idle", low_cnt, 0);

        // Reset during READ, with an ignored start while busy
        @(negedge clk);
        slave_addr = SLV; reg_addr = 8'h04; nbytes = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        nbytes = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_start_ignored_busy", busy, 1'b1);
        chk("t5_start_ignored_done", done, 1'b0);
        repeat (300) @(negedge clk);
        for (int i = 0; i < 40 && scl_padoen; i++) @(negedge clk);
        chk("t5_scl_driven_before_rst", scl_padoen, 1'b0);
        arst = 1'b0;
        #1;
        chk("t5_rst_scl_oen", scl_padoen, 1'b1);
        chk("t5_rst_sda_oen", sda_padoen, 1'b1);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_rd_data", rd_data, 32'h0);
        @(negedge clk);
        arst = 1'b1;
        run(SLV, 8'h00, 3'd2, b0, got, d2, cyc);
        chk("t5_fresh_done", got, 1'b1);
        chk("t5_fresh_rd_data", rd_data, 32'hA53C_0000);
        chk("t5_fresh_ack_err", ack_err, 1'b0);

`ifdef I2C_CLK_STRETCH_EN
        m0 = stretch_req;
        run(SLV, 8'h04, 3'd4, b0, got, d2, cyc);
        chk("t6_stretched", (stretch_req - m0) > 0, 1'b1);
        chk("t6_rd_data", rd_data, 32'h0102_0304);
        chk("t6_ack_err", ack_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
